// File: rtl/fuel_pump_pkg.sv
// Shared types and default parameters for the fuel-pump power stage.
package fuel_pump_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAMP  = 2'd1,
      RUN   = 2'd2,
      FAULT = 2'd3
   } pump_state_t;

   localparam int DEF_PWM_BITS     = 4;
   localparam int DEF_RAMP_STEP    = 2;
   localparam int DEF_FAULT_FILTER = 3;

endpackage

// File: rtl/overcurrent_filter.sv
// Counts consecutive over-current samples while enabled; trip pulses on the
// FAULT_FILTER-th consecutive high sample.
module overcurrent_filter
   import fuel_pump_pkg::*;
#(
   parameter int FAULT_FILTER = DEF_FAULT_FILTER
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic enable_i,
   input  logic sample_i,
   output logic trip_o
);

   localparam int CW = $clog2(FAULT_FILTER + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FAULT_FILTER - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      trip_o = enable_i && sample_i && (cnt_q == CNT_LAST);
      cnt_d  = cnt_q;
      // Any low sample, a disabled filter or a trip restarts the run length.
      if (!enable_i || !sample_i || trip_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fuel_pump_driver.sv
// Fuel-pump gate driver: PWM soft-start ramp, full-on run, and a latched
// over-current fault released only by a clear with the request dropped.
module fuel_pump_driver
   import fuel_pump_pkg::*;
#(
   parameter int PWM_BITS     = DEF_PWM_BITS,
   parameter int RAMP_STEP    = DEF_RAMP_STEP,
   parameter int FAULT_FILTER = DEF_FAULT_FILTER
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                fuelPumpPower,
   input  logic                overCurrent,
   input  logic                clearFault,
   output logic                pumpDrive,
   output logic                pumpRunning,
   output logic                faultLatched,
   output logic [PWM_BITS-1:0] duty
);

   localparam int SW = $clog2(RAMP_STEP + 1);
   localparam logic [SW-1:0]       STEP_LAST = SW'(RAMP_STEP - 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

   pump_state_t         state_q, state_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [SW-1:0]       step_q, step_d;
   logic                drive_q, drive_d;
   logic                running_q, running_d;
   logic                fault_q, fault_d;
   logic                oc_en, trip;

   assign oc_en = (state_q == RAMP) || (state_q == RUN);

   overcurrent_filter #(
      .FAULT_FILTER(FAULT_FILTER)
   ) u_oc_filter (
      .clock_i (clock),
      .reset_i (reset),
      .enable_i(oc_en),
      .sample_i(overCurrent),
      .trip_o  (trip)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pwm_q     <= '0;
         duty_q    <= '0;
         step_q    <= '0;
         drive_q   <= 1'b0;
         running_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pwm_q     <= pwm_d;
         duty_q    <= duty_d;
         step_q    <= step_d;
         drive_q   <= drive_d;
         running_q <= running_d;
         fault_q   <= fault_d;
      end
   end

   // Fault trip outranks request drop, which outranks ramp advance.
   always_comb begin
      state_d = state_q;
      pwm_d   = pwm_q;
      duty_d  = duty_q;
      step_d  = step_q;
      case (state_q)
         IDLE: begin
            if (fuelPumpPower) begin
               state_d = RAMP;
               pwm_d   = '0;
               step_d  = '0;
               duty_d  = PWM_BITS'(1);
            end
         end
         RAMP: begin
            if (trip) begin
               state_d = FAULT;
            end else if (!fuelPumpPower) begin
               state_d = IDLE;
            end else begin
               pwm_d = pwm_q + 1'b1;
               if (pwm_q == PWM_MAX) begin
                  if (step_q == STEP_LAST) begin
                     step_d = '0;
                     if (duty_q == PWM_MAX) begin
                        state_d = RUN;
                        pwm_d   = '0;
                     end else begin
                        duty_d = duty_q + 1'b1;
                     end
                  end else begin
                     step_d = step_q + 1'b1;
                  end
               end
            end
         end
         RUN: begin
            if (trip) begin
               state_d = FAULT;
            end else if (!fuelPumpPower) begin
               state_d = IDLE;
            end
         end
         FAULT: begin
            if (clearFault && !fuelPumpPower) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE || state_d == FAULT) begin
         pwm_d  = '0;
         step_d = '0;
         duty_d = '0;
      end
   end

   // Outputs are computed from next-state values so they settle at the same edge.
   always_comb begin
      running_d = (state_d == RUN);
      fault_d   = (state_d == FAULT);
      case (state_d)
         RAMP:    drive_d = (pwm_d < duty_d);
         RUN:     drive_d = 1'b1;
         default: drive_d = 1'b0;
      endcase
   end

   assign pumpDrive    = drive_q;
   assign pumpRunning  = running_q;
   assign faultLatched = fault_q;
   assign duty         = duty_q;

endmodule

// File: tb/tb_fuel_pump_driver.sv
// Self-checking bench for fuel_pump_driver with default parameters.
module tb_fuel_pump_driver;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       fuelPumpPower = 1'b0;
   logic       overCurrent = 1'b0;
   logic       clearFault = 1'b0;
   logic       pumpDrive, pumpRunning, faultLatched;
   logic [3:0] duty;

   int n_pass  = 0;
   int n_total = 0;

   // Observed/expected vector: {pumpDrive, pumpRunning, faultLatched, duty}
   logic [6:0] exp_q[$];
   logic [6:0] exp_v;
   logic [6:0] obs;

   localparam logic [6:0] V_IDLE  = 7'b000_0000;
   localparam logic [6:0] V_RUN   = {3'b110, 4'd15};
   localparam logic [6:0] V_FAULT = {3'b001, 4'd0};

   fuel_pump_driver dut (
      .clock        (clock),
      .reset        (reset),
      .fuelPumpPower(fuelPumpPower),
      .overCurrent  (overCurrent),
      .clearFault   (clearFault),
      .pumpDrive    (pumpDrive),
      .pumpRunning  (pumpRunning),
      .faultLatched (faultLatched),
      .duty         (duty)
   );

   always #5 clock = ~clock;

   assign obs = {pumpDrive, pumpRunning, faultLatched, duty};

   // Expected vector t edges after RAMP entry (t=0 is the entry edge).
   function automatic logic [6:0] ramp_vec(int t);
      int d;
      int p;
      if (t >= 480) return V_RUN;
      d = 1 + t / 32;
      p = t % 16;
      return {(p < d), 2'b00, 4'(d)};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #2;
      n_total++;
      if (obs !== V_IDLE) $display("FAIL reset_initial: got %b exp %b", obs, V_IDLE);
      else n_pass++;
      reset = 1'b0;
      tick();
      fuelPumpPower = 1'b1;
      for (int t = 0; t <= 200; t++) tick();
      n_total++;
      if (duty !== 4'd7) $display("FAIL reset_pre_duty7: got %0d exp 7", duty);
      else n_pass++;
      // Asynchronous reset between edges must clear outputs immediately.
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (obs !== V_IDLE) $display("FAIL reset_async_midramp: got %b exp %b", obs, V_IDLE);
      else n_pass++;
      fuelPumpPower = 1'b0;
      #2 reset = 1'b0;
      for (int i = 0; i < 6; i++) exp_q.push_back(V_IDLE);
      while (exp_q.size() > 0) begin
         tick();
         exp_v = exp_q.pop_front();
         n_total++;
         if (obs !== exp_v) $display("FAIL reset_stay_idle: got %b exp %b", obs, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_soft_start();
      int t;
      apply_reset();
      fuelPumpPower = 1'b1;
      for (int i = 0; i < 496; i++) exp_q.push_back(ramp_vec(i));
      t = 0;
      while (exp_q.size() > 0) begin
         tick();
         exp_v = exp_q.pop_front();
         n_total++;
         if (obs !== exp_v) $display("FAIL soft_start t=%0d: got %b exp %b", t, obs, exp_v);
         else n_pass++;
         t++;
      end
   endtask

   task automatic test_mid_drop();
      int t;
      apply_reset();
      fuelPumpPower = 1'b1;
      for (int i = 0; i <= 130; i++) exp_q.push_back(ramp_vec(i));
      t = 0;
      while (exp_q.size() > 0) begin
         tick();
         exp_v = exp_q.pop_front();
         n_total++;
         if (obs !== exp_v) $display("FAIL drop_ramp t=%0d: got %b exp %b", t, obs, exp_v);
         else n_pass++;
         t++;
      end
      n_total++;
      if (duty !== 4'd5) $display("FAIL drop_pre_duty5: got %0d exp 5", duty);
      else n_pass++;
      fuelPumpPower = 1'b0;
      exp_q.push_back(V_IDLE);
      exp_q.push_back(V_IDLE);
      while (exp_q.size() > 0) begin
         tick();
         exp_v = exp_q.pop_front();
         n_total++;
         if (obs !== exp_v) $display("FAIL drop_idle: got %b exp %b", obs, exp_v);
         else n_pass++;
      end
      fuelPumpPower = 1'b1;
      for (int i = 0; i < 40; i++) exp_q.push_back(ramp_vec(i));
      t = 0;
      while (exp_q.size() > 0) begin
         tick();
         exp_v = exp_q.pop_front();
         n_total++;
         if (obs !== exp_v) $display("FAIL drop_restart t=%0d: got %b exp %b", t, obs, exp_v);
         else n_pass++;
         t++;
      end
   endtask

   task automatic test_fault_filter();
      logic pat[$];
      apply_reset();
      fuelPumpPower = 1'b1;
      for (int i = 0; i <= 480; i++) tick();
      n_total++;
      if (obs !== V_RUN) $display("FAIL filter_in_run: got %b exp %b", obs, V_RUN);
      else n_pass++;
      // Broken runs of two must never trip.
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) exp_q.push_back(V_RUN);
      exp_q.push_back(V_FAULT);
      while (exp_q.size() > 0) begin
         overCurrent = pat.pop_front();
         tick();
         exp_v = exp_q.pop_front();
         n_total++;
         if (obs !== exp_v) $display("FAIL filter_seq: got %b exp %b", obs, exp_v);
         else n_pass++;
      end
      overCurrent = 1'b0;
   endtask

   task automatic test_fault_latch();
      clearFault = 1'b1;
      fuelPumpPower = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(V_FAULT);
      while (exp_q.size() > 0) begin
         tick();
         exp_v = exp_q.pop_front();
         n_total++;
         if (obs !== exp_v) $display("FAIL latch_clear_ignored: got %b exp %b", obs, exp_v);
         else n_pass++;
      end
      clearFault = 1'b0;
      fuelPumpPower = 1'b0;
      exp_q.push_back(V_FAULT);
      exp_q.push_back(V_FAULT);
      while (exp_q.size() > 0) begin
         tick();
         exp_v = exp_q.pop_front();
         n_total++;
         if (obs !== exp_v) $display("FAIL latch_no_clear: got %b exp %b", obs, exp_v);
         else n_pass++;
      end
      clearFault = 1'b1;
      tick();
      n_total++;
      if (obs !== V_IDLE) $display("FAIL latch_release: got %b exp %b", obs, V_IDLE);
      else n_pass++;
      clearFault = 1'b0;
   endtask

   task automatic test_coincident();
      int t;
      apply_reset();
      // Over-current in IDLE is ignored.
      overCurrent = 1'b1;
      for (int i = 0; i < 5; i++) exp_q.push_back(V_IDLE);
      while (exp_q.size() > 0) begin
         tick();
         exp_v = exp_q.pop_front();
         n_total++;
         if (obs !== exp_v) $display("FAIL idle_oc_ignored: got %b exp %b", obs, exp_v);
         else n_pass++;
      end
      overCurrent = 1'b0;
      fuelPumpPower = 1'b1;
      for (int i = 0; i < 52; i++) exp_q.push_back(ramp_vec(i));
      t = 0;
      while (exp_q.size() > 0) begin
         if (t >= 50) overCurrent = 1'b1;
         tick();
         exp_v = exp_q.pop_front();
         n_total++;
         if (obs !== exp_v) $display("FAIL coinc_ramp t=%0d: got %b exp %b", t, obs, exp_v);
         else n_pass++;
         t++;
      end
      fuelPumpPower = 1'b0;
      tick();
      n_total++;
      if (obs !== V_FAULT) $display("FAIL coinc_trip_wins: got %b exp %b", obs, V_FAULT);
      else n_pass++;
      overCurrent = 1'b0;
      tick();
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (obs !== V_IDLE) $display("FAIL reset_clears_fault: got %b exp %b", obs, V_IDLE);
      else n_pass++;
      #1 reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_soft_start();
      test_mid_drop();
      test_fault_filter();
      test_fault_latch();
      test_coincident();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
